// File: rtl/vta_host_dpi_axi_bridge_pkg.sv
// Shared types and constants for the host DPI to AXI4-Lite bridge.
package vta_host_axi_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WADDR,
        WRESP,
        RADDR,
        RDATA
    } state_e;

    localparam logic OP_READ  = 1'b0;
    localparam logic OP_WRITE = 1'b1;

    localparam logic [1:0] OKAY   = 2'd0;
    localparam logic [1:0] SLVERR = 2'd2;
    localparam logic [1:0] DECERR = 2'd3;

endpackage

// File: rtl/vta_host_dpi_axi_bridge_if.sv
// AXI4-Lite link between the bridge (master) and the CSR file (slave).
interface vta_host_dpi_axi_bridge_if #(
    parameter int unsigned ADDR_BITS = 16,
    parameter int unsigned DATA_BITS = 32
);
    logic                   awvalid;
    logic                   awready;
    logic [ADDR_BITS-1:0]   awaddr;
    logic                   wvalid;
    logic                   wready;
    logic [DATA_BITS-1:0]   wdata;
    logic [DATA_BITS/8-1:0] wstrb;
    logic                   bvalid;
    logic                   bready;
    logic [1:0]             bresp;
    logic                   arvalid;
    logic                   arready;
    logic [ADDR_BITS-1:0]   araddr;
    logic                   rvalid;
    logic                   rready;
    logic [DATA_BITS-1:0]   rdata;
    logic [1:0]             rresp;

    modport master (
        output awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
        input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );

    modport slave (
        input  awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
        output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );
endinterface

// File: rtl/vta_host_dpi_axi_bridge.sv
// Converts host DPI register requests into single AXI4-Lite transactions, one in flight.
module vta_host_dpi_axi_bridge
    import vta_host_axi_pkg::*;
#(
    parameter int unsigned ADDR_BITS     = 8,
    parameter int unsigned DATA_BITS     = 32,
    parameter int unsigned AXI_ADDR_BITS = 16
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   dpi_req_valid,
    input  logic                   dpi_req_opcode,
    input  logic [ADDR_BITS-1:0]   dpi_req_addr,
    input  logic [DATA_BITS-1:0]   dpi_req_value,
    output logic                   dpi_req_deq,
    output logic                   dpi_resp_valid,
    output logic [DATA_BITS-1:0]   dpi_resp_bits,
    vta_host_dpi_axi_bridge_if.master m,
    output logic                   err
);

    state_e                   state_q, state_d;
    logic                     aw_done_q, aw_done_d;
    logic                     w_done_q, w_done_d;
    logic [AXI_ADDR_BITS-1:0] addr_q, addr_d;
    logic [DATA_BITS-1:0]     data_q, data_d;
    logic                     resp_valid_q, resp_valid_d;
    logic [DATA_BITS-1:0]     resp_bits_q, resp_bits_d;
    logic                     err_q, err_d;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            aw_done_q    <= 1'b0;
            w_done_q     <= 1'b0;
            addr_q       <= '0;
            data_q       <= '0;
            resp_valid_q <= 1'b0;
            resp_bits_q  <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            aw_done_q    <= aw_done_d;
            w_done_q     <= w_done_d;
            addr_q       <= addr_d;
            data_q       <= data_d;
            resp_valid_q <= resp_valid_d;
            resp_bits_q  <= resp_bits_d;
            err_q        <= err_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        aw_done_d    = aw_done_q;
        w_done_d     = w_done_q;
        addr_d       = addr_q;
        data_d       = data_q;
        resp_valid_d = 1'b0;
        resp_bits_d  = resp_bits_q;
        err_d        = err_q;
        unique case (state_q)
            IDLE: begin
                if (dpi_req_valid) begin
                    addr_d    = AXI_ADDR_BITS'(dpi_req_addr);
                    data_d    = dpi_req_value;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    state_d   = (dpi_req_opcode == OP_WRITE) ? WADDR : RADDR;
                end
            end
            WADDR: begin
                // A ready seen after its channel is done is harmless: the flag only sets.
                aw_done_d = aw_done_q | m.awready;
                w_done_d  = w_done_q | m.wready;
                if (aw_done_d && w_done_d) begin
                    state_d = WRESP;
                end
            end
            WRESP: begin
                if (m.bvalid) begin
                    if (m.bresp != OKAY) err_d = 1'b1;
                    state_d = IDLE;
                end
            end
            RADDR: begin
                if (m.arready) state_d = RDATA;
            end
            RDATA: begin
                if (m.rvalid) begin
                    resp_valid_d = 1'b1;
                    resp_bits_d  = m.rdata;
                    if (m.rresp != OKAY) err_d = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign dpi_req_deq    = (state_q == IDLE) && dpi_req_valid;
    assign dpi_resp_valid = resp_valid_q;
    assign dpi_resp_bits  = resp_bits_q;
    assign err            = err_q;

    assign m.awvalid = (state_q == WADDR) && !aw_done_q;
    assign m.awaddr  = addr_q;
    assign m.wvalid  = (state_q == WADDR) && !w_done_q;
    assign m.wdata   = data_q;
    assign m.wstrb   = {(DATA_BITS / 8){1'b1}};
    assign m.bready  = (state_q == WRESP);
    assign m.arvalid = (state_q == RADDR);
    assign m.araddr  = addr_q;
    assign m.rready  = (state_q == RDATA);

endmodule
